// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared constants, channel state encoding and width helper
//
// Purpose : common definitions for the push-button conditioner.
// Contents: btn_state_t channel FSM encoding, button index constants,
//           default 50 MHz timing constants, counter width helper.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_UP       = 2'd0,
        ST_UP_CHK   = 2'd1,
        ST_DOWN     = 2'd2,
        ST_DOWN_CHK = 2'd3
    } btn_state_t;

    localparam int BTN_IDX_N = 0;
    localparam int BTN_IDX_S = 1;
    localparam int BTN_IDX_W = 2;
    localparam int BTN_IDX_E = 3;
    localparam int BTN_COUNT = 4;

    // 50 MHz: 20 ms debounce, 500 ms first repeat, 100 ms repeat period
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;
    localparam logic [3:0] DEF_REPEAT_MASK = 4'b1100;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - conditioned button event bundle
//
// Purpose : carries the four per-button event vectors to the display FSM.
// Signals : btn_level   - debounced level (bit 0 N, 1 S, 2 W, 3 E)
//           btn_press   - one-cycle pulse on accepted press
//           btn_release - one-cycle pulse on accepted release
//           btn_repeat  - one-cycle pulse per auto-repeat tick
// Modports: master drives the events, slave consumes them.
interface btn_conditioner_if;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_repeat;

    modport master (
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );

    modport slave (
        input btn_level,
        input btn_press,
        input btn_release,
        input btn_repeat
    );
endinterface

// File: rtl/btn_conditioner_channel.sv
// rtl/btn_conditioner_channel.sv - one button: synchroniser, debounce FSM, auto-repeat
//
// Purpose : turns one raw asynchronous button pad into registered level,
//           press, release and repeat events.
// Ports   : clk, rst_n (async active-low)
//           i_btn      - raw pad, active-high
//           o_level    - debounced level
//           o_press    - one-cycle pulse on accepted press
//           o_release  - one-cycle pulse on accepted release
//           o_repeat   - one-cycle pulse per auto-repeat tick (0 if REPEAT_EN=0)
module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RMAX);

    localparam logic [DW-1:0] DB_LIM    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LIM = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LIM   = RW'(REPEAT_PERIOD - 1);

    logic r_sync1;
    logic r_sync2;

    btn_state_t    r_state;
    btn_state_t    w_next_state;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_next;
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_next;
    logic          r_phase_period;   // 0: waiting first repeat, 1: periodic repeats
    logic          w_phase_next;
    logic          w_press;
    logic          w_release;
    logic          w_repeat;
    logic [RW-1:0] w_rlim;

    logic r_level;
    logic r_press;
    logic r_release;
    logic r_repeat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rlim = r_phase_period ? PER_LIM : DELAY_LIM;

    always_comb begin
        w_next_state = r_state;
        w_dcnt_next  = r_dcnt;
        w_rcnt_next  = r_rcnt;
        w_phase_next = r_phase_period;
        w_press      = 1'b0;
        w_release    = 1'b0;
        w_repeat     = 1'b0;
        case (r_state)
            ST_UP: begin
                if (r_sync2) begin
                    w_next_state = ST_UP_CHK;
                    w_dcnt_next  = '0;
                end
            end
            ST_UP_CHK: begin
                if (!r_sync2) begin
                    w_next_state = ST_UP;
                end else if (r_dcnt == DB_LIM) begin
                    w_next_state = ST_DOWN;
                    w_press      = 1'b1;
                    w_rcnt_next  = '0;
                    w_phase_next = 1'b0;
                end else begin
                    w_dcnt_next = r_dcnt + DW'(1);
                end
            end
            ST_DOWN: begin
                if (!r_sync2) begin
                    w_next_state = ST_DOWN_CHK;
                    w_dcnt_next  = '0;
                end else if (REPEAT_EN) begin
                    if (r_rcnt == w_rlim) begin
                        w_repeat     = 1'b1;
                        w_rcnt_next  = '0;
                        w_phase_next = 1'b1;
                    end else begin
                        w_rcnt_next = r_rcnt + RW'(1);
                    end
                end
            end
            ST_DOWN_CHK: begin
                // repeat counter is left untouched so a rejected glitch resumes it
                if (r_sync2) begin
                    w_next_state = ST_DOWN;
                end else if (r_dcnt == DB_LIM) begin
                    w_next_state = ST_UP;
                    w_release    = 1'b1;
                end else begin
                    w_dcnt_next = r_dcnt + DW'(1);
                end
            end
            default: begin
                w_next_state = ST_UP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_UP;
            r_dcnt         <= '0;
            r_rcnt         <= '0;
            r_phase_period <= 1'b0;
            r_level        <= 1'b0;
            r_press        <= 1'b0;
            r_release      <= 1'b0;
            r_repeat       <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_dcnt         <= w_dcnt_next;
            r_rcnt         <= w_rcnt_next;
            r_phase_period <= w_phase_next;
            r_level        <= (w_next_state == ST_DOWN) || (w_next_state == ST_DOWN_CHK);
            r_press        <= w_press;
            r_release      <= w_release;
            r_repeat       <= w_repeat;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - four-button conditioner feeding the LCD display FSM
//
// Purpose : synchronises, debounces and edge-detects the four board buttons;
//           west/east (by default) also auto-repeat while held.
// Ports   : clk, rst_n (async active-low)
//           BTN_NORTH, BTN_SOUTH, BTN_WEST, BTN_EAST - raw pads, active-high
//           evt (btn_conditioner_if.master) - btn_level/press/release/repeat,
//           bit 0 N, 1 S, 2 W, 3 E
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int         REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int         REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [3:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic BTN_NORTH,
    input  logic BTN_SOUTH,
    input  logic BTN_WEST,
    input  logic BTN_EAST,
    btn_conditioner_if.master evt
);

    logic [3:0] w_raw;
    logic [3:0] w_level;
    logic [3:0] w_press;
    logic [3:0] w_release;
    logic [3:0] w_repeat;

    assign w_raw[BTN_IDX_N] = BTN_NORTH;
    assign w_raw[BTN_IDX_S] = BTN_SOUTH;
    assign w_raw[BTN_IDX_W] = BTN_WEST;
    assign w_raw[BTN_IDX_E] = BTN_EAST;

    for (genvar g = 0; g < BTN_COUNT; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[g])
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_btn     (w_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_repeat  (w_repeat[g])
        );
    end

    assign evt.btn_level   = w_level;
    assign evt.btn_press   = w_press;
    assign evt.btn_release = w_release;
    assign evt.btn_repeat  = w_repeat;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed self-checking bench for btn_conditioner
module tb_btn_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_n, btn_s, btn_w, btn_e;

    btn_conditioner_if evt ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_MASK     (4'b1100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .BTN_NORTH (btn_n),
        .BTN_SOUTH (btn_s),
        .BTN_WEST  (btn_w),
        .BTN_EAST  (btn_e),
        .evt       (evt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // edge counter and per-bit event statistics, updated just after each edge
    int ecnt = 0;
    int n_press [4];
    int n_rel   [4];
    int n_rep   [4];
    int n_lvl   [4];
    int press_e [4];
    int rel_e   [4];
    int rep_first_e [4];
    int rep_last_e  [4];
    int n_press_cyc;
    int last_press_vec;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int b = 0; b < 4; b++) begin
            n_press[b] = 0; n_rel[b] = 0; n_rep[b] = 0; n_lvl[b] = 0;
            press_e[b] = -1; rel_e[b] = -1; rep_first_e[b] = -1; rep_last_e[b] = -1;
        end
        n_press_cyc    = 0;
        last_press_vec = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        for (int b = 0; b < 4; b++) begin
            if (evt.btn_press[b])   begin n_press[b]++; press_e[b] = ecnt; end
            if (evt.btn_release[b]) begin n_rel[b]++;   rel_e[b]   = ecnt; end
            if (evt.btn_repeat[b]) begin
                if (n_rep[b] == 0) rep_first_e[b] = ecnt;
                n_rep[b]++;
                rep_last_e[b] = ecnt;
            end
            if (evt.btn_level[b]) n_lvl[b]++;
        end
        if (|evt.btn_press) begin
            n_press_cyc++;
            last_press_vec = int'(evt.btn_press);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int k;
    int r;
    int total;

    initial begin
        rst_n = 1'b0;
        btn_n = 1'b0; btn_s = 1'b0; btn_w = 1'b0; btn_e = 1'b0;
        clear_stats();
        ticks(3);
        check("reset_level",   int'(evt.btn_level),   0);
        check("reset_press",   int'(evt.btn_press),   0);
        check("reset_release", int'(evt.btn_release), 0);
        check("reset_repeat",  int'(evt.btn_repeat),  0);
        rst_n = 1'b1;
        ticks(3);

        // clean EAST press held 8 cycles
        clear_stats();
        btn_e = 1'b1; k = ecnt + 1;
        ticks(8);
        btn_e = 1'b0;
        ticks(12);
        check("e_press_cnt",   n_press[3], 1);
        check("e_press_edge",  press_e[3], k + 6);
        check("e_level_cyc",   n_lvl[3],   8);
        check("e_rel_cnt",     n_rel[3],   1);
        check("e_rel_edge",    rel_e[3],   k + 14);
        check("e_repeat_cnt",  n_rep[3],   0);

        // NORTH bouncing with 2-cycle pulses
        clear_stats();
        for (int i = 0; i < 10; i++) begin
            btn_n = ~btn_n;
            ticks(2);
        end
        btn_n = 1'b0;
        ticks(10);
        total = 0;
        for (int b = 0; b < 4; b++) total += n_press[b] + n_rel[b] + n_rep[b];
        check("n_bounce_level", n_lvl[0], 0);
        check("n_bounce_events", total, 0);

        // WEST held 30 cycles, auto-repeat
        clear_stats();
        btn_w = 1'b1; k = ecnt + 1;
        ticks(30);
        btn_w = 1'b0;
        ticks(12);
        check("w_press_edge",  press_e[2],     k + 6);
        check("w_rep_first",   rep_first_e[2], k + 16);
        check("w_rep_last",    rep_last_e[2],  k + 31);
        check("w_rep_cnt",     n_rep[2],       6);
        check("w_rel_cnt",     n_rel[2],       1);
        check("w_rel_edge",    rel_e[2],       k + 36);

        // SOUTH held 30 cycles, repeat disabled
        clear_stats();
        btn_s = 1'b1;
        ticks(30);
        btn_s = 1'b0;
        ticks(12);
        check("s_press_cnt", n_press[1], 1);
        check("s_rep_cnt",   n_rep[1],   0);
        check("s_rel_cnt",   n_rel[1],   1);

        // EAST and WEST together
        clear_stats();
        btn_e = 1'b1; btn_w = 1'b1; k = ecnt + 1;
        ticks(8);
        btn_e = 1'b0; btn_w = 1'b0;
        ticks(12);
        check("ew_press_cyc", n_press_cyc,    1);
        check("ew_press_vec", last_press_vec, 12);
        check("ew_press_edge", press_e[2],    k + 6);

        // reset while EAST is held
        clear_stats();
        btn_e = 1'b1; k = ecnt + 1;
        ticks(8);
        check("rst_first_press", press_e[3], k + 6);
        rst_n = 1'b0;
        #1;
        check("rst_level",   int'(evt.btn_level),   0);
        check("rst_press",   int'(evt.btn_press),   0);
        check("rst_release", int'(evt.btn_release), 0);
        check("rst_repeat",  int'(evt.btn_repeat),  0);
        ticks(3);
        rst_n = 1'b1;
        clear_stats();
        r = ecnt + 1;
        ticks(3);
        check("rst_level_low", n_lvl[3], 0);
        ticks(7);
        check("rst_repress_cnt",  n_press[3], 1);
        check("rst_repress_edge", press_e[3], r + 6);
        btn_e = 1'b0;
        ticks(12);
        check("rst_rel_cnt", n_rel[3], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
